// File: rtl/boom_mmio_sink_if.sv
// MMIO request/response bus between the BOOM AXI-to-mem bridge and the harness sink.
interface boom_mmio_sink_if #(
  parameter int MMIO_ADDR_WIDTH = 31,
  parameter int DATA_WIDTH      = 64
);
  logic                       mmio_req_i;
  logic                       mmio_we_i;
  logic [MMIO_ADDR_WIDTH-1:0] mmio_addr_i;
  logic [DATA_WIDTH/8-1:0]    mmio_strb_i;
  logic [DATA_WIDTH-1:0]      mmio_wdata_i;
  logic [DATA_WIDTH-1:0]      mmio_rdata_o;

  modport master (
    output mmio_req_i, mmio_we_i, mmio_addr_i, mmio_strb_i, mmio_wdata_i,
    input  mmio_rdata_o
  );

  modport slave (
    input  mmio_req_i, mmio_we_i, mmio_addr_i, mmio_strb_i, mmio_wdata_i,
    output mmio_rdata_o
  );
endinterface

// File: rtl/boom_mmio_sink.sv
// Harness MMIO target: sticky stop flag, free-running cycle counter and a dump FIFO
// drained over a valid/ready stream. Reads respond one cycle after the request.
module boom_mmio_sink #(
  parameter int                         MMIO_ADDR_WIDTH = 31,
  parameter int                         DATA_WIDTH      = 64,
  parameter int                         FIFO_DEPTH      = 8,
  parameter logic [MMIO_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                  clock,
  input  logic                  reset_wire_reset,
  boom_mmio_sink_if.slave       mmio,
  output logic                  stop_o,
  output logic [31:0]           stop_code_o,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [DATA_WIDTH-1:0] dump_data_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic                  stop_q;
  logic [31:0]           stop_code_q;
  logic                  overflow_q;
  logic [63:0]           cycle_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  hit;
  logic [1:0]            sel;
  logic                  rd_req;
  logic                  stop_wr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr_lsbs;

  assign hit              = mmio.mmio_addr_i[MMIO_ADDR_WIDTH-1:5] == BASE_ADDR[MMIO_ADDR_WIDTH-1:5];
  assign sel              = mmio.mmio_addr_i[4:3];
  assign unused_addr_lsbs = ^mmio.mmio_addr_i[2:0];

  assign rd_req  = mmio.mmio_req_i && !mmio.mmio_we_i;
  assign stop_wr = mmio.mmio_req_i && mmio.mmio_we_i && hit && (sel == 2'd0)
                   && mmio.mmio_strb_i[0] && mmio.mmio_wdata_i[0];
  assign push    = mmio.mmio_req_i && mmio.mmio_we_i && hit && (sel == 2'd1)
                   && (|mmio.mmio_strb_i);

  assign dump_valid_o = (count_q != '0);
  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign pop          = dump_valid_o && dump_ready_i;
  // A pop in the same cycle frees the slot the push needs, so full+pop is not an overflow.
  assign push_ok      = push && (!full || pop);
  assign dump_data_o  = mem[rd_ptr_q];

  always_comb begin
    push_data = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (mmio.mmio_strb_i[b]) push_data[8*b +: 8] = mmio.mmio_wdata_i[8*b +: 8];
    end
  end

  always_comb begin
    status       = '0;
    status[0]    = stop_q;
    status[1]    = overflow_q;
    status[15:8] = 8'(count_q);
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      2'd0:    rd_val = {31'b0, stop_code_q, stop_q};
      2'd1:    rd_val = '0;
      2'd2:    rd_val = cycle_q;
      default: rd_val = status;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_wire_reset) begin
      stop_q      <= 1'b0;
      stop_code_q <= '0;
      cycle_q     <= '0;
      rdata_q     <= '0;
    end else begin
      if (stop_wr) begin
        stop_q <= 1'b1;
        if (!stop_q) stop_code_q <= mmio.mmio_wdata_i[31:0];
      end
      // Counter still advances in the stopping cycle, then freezes.
      if (!stop_q) cycle_q <= cycle_q + 64'd1;
      if (rd_req) rdata_q <= hit ? rd_val : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_wire_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push && full && !pop) overflow_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign mmio.mmio_rdata_o = rdata_q;
  assign stop_o            = stop_q;
  assign stop_code_o       = stop_code_q;

endmodule
